// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CTRL/STATUS bit positions and the
// control register layout shared by the UART CSR block.
package uart_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_DVSR   = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_RXDATA = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    localparam int CTRL_W = 4;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    // Field order gives bit0 tx_en .. bit3 tx_ie.
    typedef struct packed {
        logic tx_ie;
        logic rx_ie;
        logic two_stop;
        logic tx_en;
    } ctrl_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: falling-edge FIFO with async active-high reset.
// Ports: push/din write, pop/dout read, full/empty/count status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~do_pop)
                count <= count + CW'(1);
            else if (do_pop & ~do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: memory-mapped UART CSRs with TX/RX FIFOs, sticky
// errors (W1C) and level irq. Bus in, serialiser handshake out.
module uart_csr_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int DVSR_W   = 11,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       cout,
    output logic [DVSR_W-1:0] dvsr,
    output logic              two_stop_bit,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    ctrl_t             ctrl;
    logic              tx_ovf;
    logic              rx_ovr;

    logic              sel_tx;
    logic              sel_dvsr;
    logic              sel_ctrl;
    logic              sel_rx;
    logic              sel_stat;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [TCW-1:0]    tx_count;

    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [RCW-1:0]    rx_count;
    logic [DATA_W-1:0] rx_head;

    logic              w1c;
    logic              tx_ovf_set;
    logic              rx_ovr_set;
    logic [31:0]       status;
    logic              unused_data;

    assign sel_tx   = (address == ADDR_W'(OFF_TXDATA));
    assign sel_dvsr = (address == ADDR_W'(OFF_DVSR));
    assign sel_ctrl = (address == ADDR_W'(OFF_CTRL));
    assign sel_rx   = (address == ADDR_W'(OFF_RXDATA));
    assign sel_stat = (address == ADDR_W'(OFF_STATUS));

    assign tx_valid = ctrl.tx_en & ~tx_empty;
    assign tx_push  = write_enable & sel_tx;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_pop   = read_enable & sel_rx & ~rx_empty;

    assign w1c        = write_enable & sel_stat;
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;

    assign two_stop_bit = ctrl.two_stop;
    assign unused_data  = ^data_in;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (data_in[DATA_W-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            dvsr   <= '0;
            ctrl   <= '0;
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            if (write_enable & sel_dvsr)
                dvsr <= data_in[DVSR_W-1:0];
            if (write_enable & sel_ctrl)
                ctrl <= ctrl_t'(data_in[CTRL_W-1:0]);
            // Set has priority over a same-edge clear.
            tx_ovf <= tx_ovf_set
                    | (tx_ovf & ~(w1c & data_in[ST_TX_OVF]));
            rx_ovr <= rx_ovr_set
                    | (rx_ovr & ~(w1c & data_in[ST_RX_OVR]));
        end
    end

    always_comb begin
        status                  = '0;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_FULL]      = rx_full;
        status[ST_RX_EMPTY]     = rx_empty;
        status[ST_TX_OVF]       = tx_ovf;
        status[ST_RX_OVR]       = rx_ovr;
        status[ST_TX_CNT +: 8]  = 8'(tx_count);
        status[ST_RX_CNT +: 8]  = 8'(rx_count);
    end

    always_comb begin
        cout = '0;
        unique case (1'b1)
            sel_tx:   cout[31] = tx_full;
            sel_dvsr: cout[DVSR_W-1:0] = dvsr;
            sel_ctrl: cout[CTRL_W-1:0] = ctrl;
            sel_rx: begin
                // Head is masked so an empty read returns zero.
                if (!rx_empty) begin
                    cout[31]         = 1'b1;
                    cout[DATA_W-1:0] = rx_head;
                end
            end
            sel_stat: cout = status;
            default:  cout = '0;
        endcase
    end

    assign irq = (ctrl.rx_ie & ~rx_empty)
               | (ctrl.tx_ie & tx_empty)
               | tx_ovf
               | rx_ovr;

endmodule
